// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD fraction reducer: default width, FSM encoding
// and the counter-width helper.
package gcd_pkg;

    localparam int unsigned GCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_div_unit.sv
// One W-bit restoring shift-subtract divider; load captures the operands, each
// step retires one quotient bit. The _c outputs show the result of the current step.
module gcd_div_unit #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient_c,
    output logic [W-1:0] remainder_c
);

    logic [W-1:0] acc;
    logic [W-1:0] rem;
    logic [W-1:0] dvs;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         ge;

    // rem < dvs holds between steps, so the shifted value is below 2*dvs and
    // the difference always fits back into W bits.
    always_comb begin
        shifted     = {rem, acc[W-1]};
        diff        = shifted - {1'b0, dvs};
        ge          = (shifted >= {1'b0, dvs});
        quotient_c  = {acc[W-2:0], ge};
        remainder_c = ge ? diff[W-1:0] : shifted[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            acc <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            acc <= quotient_c;
            rem <= remainder_c;
        end
    end

endmodule

// File: rtl/gcd_fraction_reducer.sv
// Reduces num/den by their gcd using two parallel restoring dividers.
// Build option GCD_REDUCER_REM_CHECK_EN: also flag err on a nonzero remainder.
module gcd_fraction_reducer
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] num_in,
    input  logic [W-1:0] den_in,
    input  logic [W-1:0] gcd_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] num_out,
    output logic [W-1:0] den_out,
    output logic         err
);

    localparam int unsigned CW = clog2(W);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          out_valid_d;
    logic [W-1:0]  num_out_d, den_out_d;
    logic          err_d;
    logic          load;
    logic          step;
    logic          rem_err;
    logic [W-1:0]  num_quo, den_quo, num_rem, den_rem;

    assign in_ready = (state == IDLE);
    assign load     = (state == IDLE) && in_valid && (gcd_in != '0);
    assign step     = (state == DIV);

`ifdef GCD_REDUCER_REM_CHECK_EN
    assign rem_err = (num_rem != '0) || (den_rem != '0);
`else
    logic unused_rem;
    assign unused_rem = |{num_rem, den_rem};
    assign rem_err    = 1'b0;
`endif

    gcd_div_unit #(.W(W)) u_num_div (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .dividend   (num_in),
        .divisor    (gcd_in),
        .quotient_c (num_quo),
        .remainder_c(num_rem)
    );

    gcd_div_unit #(.W(W)) u_den_div (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .dividend   (den_in),
        .divisor    (gcd_in),
        .quotient_c (den_quo),
        .remainder_c(den_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        num_out_d   = num_out;
        den_out_d   = den_out;
        err_d       = err;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (gcd_in != '0) begin
                        cnt_d   = CW'(W - 1);
                        state_d = DIV;
                    end else begin
                        // Division by zero: pass operands through, flagged.
                        num_out_d   = num_in;
                        den_out_d   = den_in;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DIV: begin
                cnt_d = cnt - CW'(1);
                if (cnt == '0) begin
                    num_out_d   = num_quo;
                    den_out_d   = den_quo;
                    err_d       = rem_err;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            num_out   <= '0;
            den_out   <= '0;
            err       <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            num_out   <= num_out_d;
            den_out   <= den_out_d;
            err       <= err_d;
        end
    end

endmodule

// File: doc/gcd_fraction_reducer.md
Name: gcd_fraction_reducer

Overview:
- Downstream consumer of the GCD datapath.
- Takes an operand pair (num, den) plus the gcd computed for that pair, and returns the reduced fraction num/gcd, den/gcd.
- Uses a multi-cycle restoring shift-subtract divider with valid/ready handshakes on both sides.
- Sits between the GCD stage and any result sink.

Parameters:
- W, 4, operand/gcd/result width in bits (W >= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents num_in/den_in/gcd_in.
- in_ready  output  1  block can accept; high only in IDLE.
- num_in  input  W  numerator operand (unsigned).
- den_in  input  W  denominator operand (unsigned).
- gcd_in  input  W  gcd of num_in, den_in, from the GCD stage.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  downstream accepts result.
- num_out  output  W  reduced numerator.
- den_out  output  W  reduced denominator.
- err  output  1  result flagged invalid (see Behaviour).

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, out_valid=0, num_out=0, den_out=0, err=0; in_ready=1 after the reset edge.
- Reset has priority over all other activity in every state. It aborts any division in flight; no result is emitted.
- All arithmetic is unsigned W-bit. No widening of outputs.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture num_in, den_in, gcd_in.
  - If gcd_in != 0: load both dividers, set iteration counter to W-1, go to DIV.
  - If gcd_in == 0: num_out=num_in, den_out=den_in, err=1, go to DONE. No DIV cycles.
- DIV:
  - in_ready=0.
  - Each edge performs one restoring step in both dividers in parallel. Shift remainder left by one, bring in the next dividend MSB, subtract the divisor if remainder >= divisor, shift in the quotient bit.
  - The counter decrements each edge.
  - On the edge where the counter is 0: latch quotients into num_out/den_out, set err (see Optional Feature), go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - num_out, den_out and err are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
- Latency: out_valid rises exactly W edges after the accepting edge (gcd != 0), or 1 edge after it (gcd == 0).
- Throughput: one result per W+2 cycles minimum.
- in_valid is ignored outside IDLE. Upstream must hold its data until in_ready is seen.
- num_in=0 gives num_out=0 with no error.
- Outputs are registered. in_ready is decoded from the state register only.

Optional Feature:
- Macro: GCD_REDUCER_REM_CHECK_EN.
- Defined: err is also set when either divider's final remainder is nonzero, i.e. gcd_in did not divide an operand exactly. Quotients are still output.
- Undefined: remainders are discarded, and err is set only for gcd_in == 0.

Decomposition:
- Shared package/include gcd_pkg holds:
  - default width constant GCD_W=4;
  - FSM state encodings (IDLE=2'd0, DIV=2'd1, DONE=2'd2);
  - the counter-width function clog2(W).
- Sub-module gcd_div_unit:
  - one W-bit restoring divider with load/step ports, quotient and remainder outputs;
  - instantiated twice (numerator and denominator);
  - the FSM and counter stay in the top.

Test Plan:
- num=12, den=8, gcd=4, out_ready=1 -> num_out=3, den_out=2, err=0; out_valid exactly 4 edges after accept, 1 cycle wide.
- num=15, den=5, gcd=5 -> 3, 1, err=0. Then num=0, den=7, gcd=7 -> 0, 1, err=0.
- gcd=0, num=9, den=6 -> out_valid 1 edge after accept; num_out=9, den_out=6, err=1.
- Backpressure, num=12, den=8, gcd=4:
  - hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0;
  - a new in_valid pulse is ignored;
  - out_ready=1 -> IDLE next edge.
- Assert reset for one edge during DIV (2nd iteration) -> next cycle IDLE, out_valid=0, outputs 0, in_ready=1; no result emitted.
- num=9, den=6, gcd=4 -> num_out=2, den_out=1:
  - with GCD_REDUCER_REM_CHECK_EN: err=1;
  - without it: err=0.
